sub_2p: RTL and testbench

- Two-stage pipelined unsigned subtractor, diff = X - Y.
- Companion to the team's pipelined 15-bit adder; inverse datapath, same operand widths.
- Low part of the difference resolved in stage 1, high part in stage 2 with the registered borrow.
- Adds a valid/ready stream handshake so it can sit between buffered datapath blocks with backpressure.

---
 rtl/sub_2p_if.sv | 23 ++
 rtl/sub_2p.sv | 94 +++++++++
 tb/tb_sub_2p.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sub_2p_if.sv
// Valid/ready stream bundle for the two-stage subtractor: operand beat in, difference beat out.
interface sub_2p_if #(
    parameter int unsigned WIDTH = 15
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output in_valid, X, Y, out_ready,
        input  in_ready, out_valid, diff, borrow
    );

    modport slave (
        input  in_valid, X, Y, out_ready,
        output in_ready, out_valid, diff, borrow
    );
endinterface

// File: rtl/sub_2p.sv
// Two-stage pipelined unsigned subtractor (diff = X - Y) with valid/ready backpressure.
// Define SUB_2P_SATURATE_EN to floor the result at zero whenever a borrow occurs.
module sub_2p #(
    parameter int unsigned WIDTH = 15,
    parameter int unsigned LO_W  = 7
) (
    input logic    clk,
    input logic    rst_n,
    sub_2p_if.slave bus
);
    localparam int unsigned HiW = WIDTH - LO_W;

    logic             adv1, adv2, accept;
    logic [LO_W:0]    lo_full;
    logic [HiW:0]     hi_full;

    logic             s1_valid_q, s1_valid_d;
    logic [LO_W-1:0]  lo_diff_q, lo_diff_d;
    logic             lo_borrow_q, lo_borrow_d;
    logic [HiW-1:0]   x_hi_q, x_hi_d;
    logic [HiW-1:0]   y_hi_q, y_hi_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    always_comb begin
        adv2    = !s2_valid_q || bus.out_ready;
        adv1    = !s1_valid_q || adv2;
        accept  = bus.in_valid && adv1;
        // Extra MSB of each slice subtraction is its borrow out.
        lo_full = {1'b0, bus.X[LO_W-1:0]} - {1'b0, bus.Y[LO_W-1:0]};
        hi_full = {1'b0, x_hi_q} - {1'b0, y_hi_q} - {{HiW{1'b0}}, lo_borrow_q};

        s1_valid_d  = s1_valid_q;
        lo_diff_d   = lo_diff_q;
        lo_borrow_d = lo_borrow_q;
        x_hi_d      = x_hi_q;
        y_hi_d      = y_hi_q;
        s2_valid_d  = s2_valid_q;
        diff_d      = diff_q;
        borrow_d    = borrow_q;

        if (adv1) begin
            s1_valid_d = bus.in_valid;
        end
        if (accept) begin
            lo_diff_d   = lo_full[LO_W-1:0];
            lo_borrow_d = lo_full[LO_W];
            x_hi_d      = bus.X[WIDTH-1:LO_W];
            y_hi_d      = bus.Y[WIDTH-1:LO_W];
        end

        if (adv2) begin
            s2_valid_d = s1_valid_q;
        end
        if (adv2 && s1_valid_q) begin
            diff_d   = {hi_full[HiW-1:0], lo_diff_q};
            borrow_d = hi_full[HiW];
`ifdef SUB_2P_SATURATE_EN
            if (hi_full[HiW]) begin
                diff_d = '0;
            end
`else
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            lo_diff_q   <= '0;
            lo_borrow_q <= 1'b0;
            x_hi_q      <= '0;
            y_hi_q      <= '0;
            s2_valid_q  <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            lo_diff_q   <= lo_diff_d;
            lo_borrow_q <= lo_borrow_d;
            x_hi_q      <= x_hi_d;
            y_hi_q      <= y_hi_d;
            s2_valid_q  <= s2_valid_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
        end
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = s2_valid_q;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
endmodule

// File: tb/tb_sub_2p.sv
// Bench for sub_2p: directed beats with literal results plus randomized traffic against a queue model.
module tb_sub_2p;
    localparam int unsigned W = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sub_2p_if #(.WIDTH(W)) bus ();

    sub_2p #(.WIDTH(W), .LO_W(7)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [W-1:0] diff;
        logic         brw;
        int           acc;
    } exp_t;

    exp_t         mq[$];
    logic [W-1:0] log_diff[$];
    logic         log_brw[$];
    int           log_cyc[$];
    int           acc_cyc[$];
    int           nvec = 0;
    int           nfail = 0;
    int           cyc = 0;
    bit           saw_stall = 0;
    bit           stop = 0;
    bit           exp_ov;
    int           n0, a0;

    task automatic check(input string name, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference result straight from integer arithmetic on the operands.
    function automatic exp_t model(input int x, input int y, input int c);
        exp_t e;
        int   d;
        d     = x - y;
        e.brw = (d < 0);
        e.diff = W'(d & ((1 << W) - 1));
`ifdef SUB_2P_SATURATE_EN
        if (d < 0) e.diff = '0;
`endif
        e.acc = c;
        return e;
    endfunction

    // Monitor samples 1ns before each rising edge: sees the handshakes about to fire.
    always begin
        @(negedge clk);
        #4;
        if (!rst_n) begin
            mq.delete();
        end else begin
            check("in_ready", longint'(bus.in_ready), longint'((mq.size() < 2) || bus.out_ready));
            exp_ov = (mq.size() > 0) && (cyc - mq[0].acc >= 2);
            check("out_valid", longint'(bus.out_valid), longint'(exp_ov));
            if (bus.out_valid && mq.size() > 0) begin
                check("diff", longint'(bus.diff), longint'(mq[0].diff));
                check("borrow", longint'(bus.borrow), longint'(mq[0].brw));
            end
            if (!bus.in_ready) saw_stall = 1;
            if (bus.out_valid && bus.out_ready) begin
                log_diff.push_back(bus.diff);
                log_brw.push_back(bus.borrow);
                log_cyc.push_back(cyc);
                if (mq.size() > 0) void'(mq.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                mq.push_back(model(int'(bus.X), int'(bus.Y), cyc));
                acc_cyc.push_back(cyc);
            end
        end
        cyc++;
    end

    // Called at a falling edge; returns at the falling edge after the beat is taken.
    task automatic send(input int x, input int y);
        int n;
        bit ok;
        n = 0;
        bus.in_valid = 1'b1;
        bus.X = W'(x);
        bus.Y = W'(y);
        do begin
            #4;
            ok = bus.in_ready;
            @(negedge clk);
            n++;
        end while (!ok && n < 200);
        if (!ok) begin
            nvec++;
            nfail++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.X = W'($urandom);
        bus.Y = W'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_beat(input string name, input int idx, input int ediff, input int ebrw);
        if (idx >= log_diff.size()) begin
            nvec++;
            nfail++;
            $display("FAIL %s: beat %0d missing, got %0d beats", name, idx, log_diff.size());
        end else begin
            check({name, "_diff"}, longint'(log_diff[idx]), longint'(ediff));
            check({name, "_borrow"}, longint'(log_brw[idx]), longint'(ebrw));
        end
    endtask

    task automatic chk_gap(input string name, input int li, input int ai, input int exp);
        if (li >= log_cyc.size() || ai >= acc_cyc.size()) begin
            nvec++;
            nfail++;
            $display("FAIL %s: beat missing, got %0d beats, required index %0d", name,
                     log_cyc.size(), li);
        end else begin
            check(name, longint'(log_cyc[li] - acc_cyc[ai]), longint'(exp));
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.X         = '0;
        bus.Y         = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_diff", longint'(bus.diff), 0);
        check("rst_borrow", longint'(bus.borrow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", longint'(bus.in_ready), 1);
        @(negedge clk);

        // Basic latency
        n0 = log_diff.size();
        a0 = acc_cyc.size();
        send(10, 0);
        idle(4);
        chk_beat("basic", n0, 10, 0);
        chk_gap("basic_latency", n0, a0, 2);

        // Back-to-back stream, last one borrows across the slice boundary
        n0 = log_diff.size();
        send('h04AA, 'h0057);
        send('h07D2, 'h07D2);
        send('h0080, 'h0001);
        idle(5);
        chk_beat("stream0", n0, 'h0453, 0);
        chk_beat("stream1", n0 + 1, 'h0000, 0);
        chk_beat("stream2", n0 + 2, 'h007F, 0);
        chk_gap("stream_gap1", n0 + 2, 0, log_cyc.size() > n0 + 2 ? log_cyc[n0 + 1] + 1 - acc_cyc[0] : -1);
        if (log_cyc.size() > n0 + 1) check("stream_gap0", longint'(log_cyc[n0 + 1] - log_cyc[n0]), 1);

        // Underflow and equal operands at full width
        n0 = log_diff.size();
        send('h0000, 'h0001);
        send('h7FFF, 'h7FFF);
        idle(5);
`ifdef SUB_2P_SATURATE_EN
        chk_beat("underflow", n0, 'h0000, 1);
`else
        chk_beat("underflow", n0, 'h7FFF, 1);
`endif
        chk_beat("equal", n0 + 1, 'h0000, 0);

        // Backpressure: out_ready low for four cycles while four beats are offered
        n0 = log_diff.size();
        saw_stall = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(100 + 3 * i, i);
                idle(1);
            end
            begin
                repeat (2) @(negedge clk);
                bus.out_ready = 1'b0;
                repeat (4) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        idle(6);
        check("bp_stall_seen", longint'(saw_stall), 1);
        check("bp_beat_count", longint'(log_diff.size() - n0), 4);
        for (int i = 0; i < 4; i++) chk_beat("bp", n0 + i, 100 + 2 * i, 0);

        // Reset with both stages full
        bus.out_ready = 1'b0;
        send(1, 0);
        send(2, 0);
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", longint'(bus.out_valid), 0);
        check("midrst_diff", longint'(bus.diff), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        n0 = log_diff.size();
        bus.out_ready = 1'b1;
        idle(4);
        check("midrst_no_stale", longint'(log_diff.size() - n0), 0);
        a0 = acc_cyc.size();
        send(5, 3);
        idle(4);
        chk_beat("post_rst", n0, 2, 0);
        chk_gap("post_rst_latency", n0, a0, 2);

        // Randomized traffic with random backpressure
        stop = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        int v;
                        v = int'($urandom);
                        send(v, v);
                    end else begin
                        send(int'($urandom), int'($urandom));
                    end
                    if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
                end
                idle(0);
                stop = 1;
            end
            begin
                while (!stop) begin
                    @(negedge clk);
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        idle(1);
        for (int n = 0; n < 50 && mq.size() > 0; n++) @(negedge clk);
        check("drain_empty", longint'(mq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
